div_sqrt_iterative_unit: RTL and testbench
==========================================

# div_sqrt_iterative_unit

Multi-cycle radix-2 fraction divider / square-root engine that services the calculation unit's division/sqrt start–done request. The initiator pulses `start` with aligned significands and waits for `done`. The engine then produces one quotient/root bit per cycle, followed by the final remainder used for sticky/rounding. It sits behind the calculation stage and is the only multi-cycle element in the FPU datapath.

## Interface
Parameters:
- `INWIDTH`, default 25: operand width.
- `OUTWIDTH`, default 26: quotient/root width, equal to the iteration count.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `mode`, in, 1: operation select. 0 = divide, 1 = square root. Sampled only with an accepted `start`.
- `start`, in, 1: request.
- `dividend_in`, in, INWIDTH: dividend, format 1.(INWIDTH-1). Ignored in sqrt.
- `divisor_radicand_in`, in, INWIDTH: operand whose format depends on `mode`.
  - Divide: divisor, format 1.(INWIDTH-1).
  - Sqrt: radicand, format xx.(INWIDTH-2), value in [1,4).
- `busy`, out, 1: iteration in progress.
- `done`, out, 1: one-cycle completion pulse.
- `quotient_root`, out, OUTWIDTH: result, format x.(OUTWIDTH-1).
- `remainder`, out, INWIDTH+2: final partial remainder, unsigned and zero-extended.

## Operation
- The FSM has three states: IDLE, RUN, FIN.
  - IDLE → RUN on `start`=1. Operands and `mode` are latched, and the iteration counter is loaded with OUTWIDTH-1.
  - RUN: one restoring step per cycle. The counter decrements. At counter 0 the state moves to FIN and `quotient_root`/`remainder` are registered.
  - FIN → IDLE unconditionally.
- `start` is ignored in RUN and FIN; there is no queueing. The initiator masks `start` with `done`.
- Divide, with integers Di and Vi:
  - Q = floor(Di·2^(OUTWIDTH-1) / Vi)
  - R = Di·2^(OUTWIDTH-1) − Q·Vi, where 0 ≤ R < Vi
- Sqrt, with integer Xi and K = 2(OUTWIDTH-1) − (INWIDTH-2), which is 27 at the defaults:
  - Q = floor(sqrt(Xi·2^K))
  - R = Xi·2^K − Q², where 0 ≤ R ≤ 2Q
- Partial-remainder and trial-subtract datapath is INWIDTH+3 bits wide, with no overflow at any step. This is mandatory for sqrt.
- Divisor = 0: Q = all ones and R = Di zero-extended. No hang; latency is unchanged.
- `quotient_root` and `remainder` change only on the RUN→FIN edge and hold until the next completion.
- Reset (asynchronous, `reset`=0): state → IDLE, counter = 0. Every output is 0: `busy`, `done`, `quotient_root`, `remainder`. An in-flight operation is discarded and no `done` is produced.

## Timing
- `start` is sampled at rising edge E0 while in IDLE.
- `busy` = 1 from after E0 until after E(OUTWIDTH), for exactly OUTWIDTH cycles.
- `done` = 1 for one cycle, from after E(OUTWIDTH) to after E(OUTWIDTH+1). `busy` = 0 during that cycle.
  - The results are valid in the same cycle as `done`.
  - Latency is 26 cycles at the defaults.
- The earliest next accepted `start` is at edge E(OUTWIDTH+2). The throughput is one operation per OUTWIDTH+2 cycles.
- A `start` held continuously high re-triggers at every IDLE sample: E0, E(OUTWIDTH+2), and so on.
- Operand inputs may change freely after E0; only the latched copies are used.
- Reset deassertion has no cycle requirement. The first `start` is accepted at the first rising edge where `reset`=1.

## Test plan
All scenarios use INWIDTH=25 and OUTWIDTH=26.

- **Divide 1.0/1.0:** dividend 25'h1000000, divisor 25'h1000000, `mode`=0 → after 26 cycles `done`=1, Q=26'h2000000, R=0.
- **Divide 1.0/1.5:** dividend 25'h1000000, divisor 25'h1800000 → Q=26'h1555555, R=27'h0800000. `busy` is high for exactly 26 cycles.
- **Sqrt 1.0 and sqrt 2.25:**
  - Radicand 25'h0800000, `mode`=1 → Q=26'h2000000, R=0.
  - Radicand 25'h1200000 → Q=26'h3000000, R=0.
- **`start` ignored and held high:**
  - `start` pulses at cycles 5 and 25 after an accepted start → ignored; exactly one `done`; results unchanged.
  - `start` held high for 100 cycles → `done` at cycles 26, 54 and 82.
- **Reset mid-operation:** `reset`=0 at cycle 10 of a divide → `busy`, `done`, Q and R are 0 immediately, with no later `done`. After release, 1.0/1.5 again gives Q=26'h1555555.
- **Divide by zero:** divisor 25'h0000000, dividend 25'h1000000 → `done` at cycle 26, Q=26'h3FFFFFF, R=27'h1000000.

Source files
------------

// File: rtl/div_sqrt_iterative_unit.sv
// Radix-2 restoring fraction divider / square-root engine: one quotient or root
// bit per cycle, then the final partial remainder for sticky/rounding.
module div_sqrt_iterative_unit #(
    parameter int INWIDTH  = 25,
    parameter int OUTWIDTH = 26
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mode,
    input  logic                  start,
    input  logic [INWIDTH-1:0]    dividend_in,
    input  logic [INWIDTH-1:0]    divisor_radicand_in,
    output logic                  busy,
    output logic                  done,
    output logic [OUTWIDTH-1:0]   quotient_root,
    output logic [INWIDTH+1:0]    remainder
);

    localparam int W  = INWIDTH + 3;
    localparam int NW = 2 * OUTWIDTH;
    localparam int CW = $clog2(OUTWIDTH);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                mode_q, mode_d;
    logic                dz_q, dz_d;
    logic [INWIDTH-1:0]  div_q, div_d;
    logic [NW-1:0]       rad_q, rad_d;
    logic [W-1:0]        r_q, r_d;
    logic [OUTWIDTH-1:0] q_q, q_d;
    logic [OUTWIDTH-1:0] quot_q, quot_d;
    logic [INWIDTH+1:0]  rem_q, rem_d;

    logic [W-1:0]        pr;
    logic [W-1:0]        sub;
    logic [W-1:0]        rsel;
    logic                ge;
    logic                last;

    // Sqrt brings down the next radicand bit pair; divide compares the already
    // doubled remainder against the divisor.
    always_comb begin
        pr   = mode_q ? {r_q[W-3:0], rad_q[NW-1 -: 2]} : r_q;
        sub  = mode_q ? W'({q_q, 2'b01}) : W'(div_q);
        ge   = (pr >= sub);
        rsel = ge ? (pr - sub) : pr;
        last = (cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        dz_d    = dz_q;
        div_d   = div_q;
        rad_d   = rad_q;
        r_d     = r_q;
        q_d     = q_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = CW'(OUTWIDTH - 1);
                    mode_d  = mode;
                    div_d   = divisor_radicand_in;
                    dz_d    = !mode && (divisor_radicand_in == '0);
                    rad_d   = NW'(divisor_radicand_in) << (NW - INWIDTH);
                    r_d     = mode ? '0 : W'(dividend_in);
                    q_d     = '0;
                end
            end
            RUN: begin
                q_d   = {q_q[OUTWIDTH-2:0], ge};
                rad_d = rad_q << 2;
                // A zero divisor keeps the remainder frozen at the dividend so
                // every step yields a 1 bit and nothing overflows.
                r_d   = (mode_q || last || dz_q) ? rsel : (rsel << 1);
                cnt_d = last ? '0 : (cnt_q - 1'b1);
                if (last) begin
                    state_d = FIN;
                    quot_d  = {q_q[OUTWIDTH-2:0], ge};
                    rem_d   = rsel[INWIDTH+1:0];
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            dz_q    <= 1'b0;
            div_q   <= '0;
            rad_q   <= '0;
            r_q     <= '0;
            q_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dz_q    <= dz_d;
            div_q   <= div_d;
            rad_q   <= rad_d;
            r_q     <= r_d;
            q_q     <= q_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
        end
    end

    assign busy          = (state_q == RUN);
    assign done          = (state_q == FIN);
    assign quotient_root = quot_q;
    assign remainder     = rem_q;

endmodule

// File: tb/tb_div_sqrt_iterative_unit.sv
// Directed bench for div_sqrt_iterative_unit: expected results and start cycles
// are queued at issue time and a negedge monitor checks each done.
module tb_div_sqrt_iterative_unit;

    logic        clk;
    logic        reset;
    logic        mode;
    logic        start;
    logic [24:0] dividend_in;
    logic [24:0] divisor_radicand_in;
    logic        busy;
    logic        done;
    logic [25:0] quotient_root;
    logic [26:0] remainder;

    div_sqrt_iterative_unit #(.INWIDTH(25), .OUTWIDTH(26)) dut (
        .clk                 (clk),
        .reset               (reset),
        .mode                (mode),
        .start               (start),
        .dividend_in         (dividend_in),
        .divisor_radicand_in (divisor_radicand_in),
        .busy                (busy),
        .done                (done),
        .quotient_root       (quotient_root),
        .remainder           (remainder)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // scoreboard state
    logic [52:0] exp_q[$];
    int          exp_t_q[$];
    int          tests     = 0;
    int          fails     = 0;
    int          done_cnt  = 0;
    int          busy_run  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitor
    always @(negedge clk) begin
        if (!reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
                end else begin
                    logic [52:0] e;
                    int          t;
                    e = exp_q.pop_front();
                    t = exp_t_q.pop_front();
                    check("quotient_root", 64'(quotient_root), 64'(e[52:27]));
                    check("remainder", 64'(remainder), 64'(e[26:0]));
                    check("latency", 64'(cyc - t), 64'd26);
                    check("busy_cycles", 64'(busy_run), 64'd26);
                    check("busy_at_done", 64'(busy), 64'd0);
                end
                busy_run = 0;
            end
        end
    end

    // driver tasks
    task automatic issue(input logic m, input logic [24:0] a, input logic [24:0] b,
                         input logic [25:0] eq, input logic [26:0] er);
        @(negedge clk);
        mode = m;
        dividend_in = a;
        divisor_radicand_in = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        exp_q.push_back({eq, er});
        exp_t_q.push_back(cyc);
        dividend_in = 25'($urandom);
        divisor_radicand_in = 25'($urandom);
        mode = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
            exp_t_q.delete();
        end
        @(negedge clk);
    endtask

    task automatic wait_until(input int target);
        for (int i = 0; i < 300 && cyc < target; i++) @(negedge clk);
    endtask

    initial begin
        int t0;
        int d0;
        reset = 1'b1;
        mode = 1'b0;
        start = 1'b0;
        dividend_in = '0;
        divisor_radicand_in = '0;
        #1 reset = 1'b0;
        @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_q", 64'(quotient_root), 64'd0);
        check("reset_r", 64'(remainder), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // directed divides and roots
        issue(1'b0, 25'h1000000, 25'h1000000, 26'h2000000, 27'h0000000); wait_drain();
        issue(1'b0, 25'h1000000, 25'h1800000, 26'h1555555, 27'h0800000); wait_drain();
        issue(1'b0, 25'h1C00000, 25'h1400000, 26'h2CCCCCC, 27'h1000000); wait_drain();
        issue(1'b0, 25'h1FFFFFF, 25'h1000000, 26'h3FFFFFE, 27'h0000000); wait_drain();
        issue(1'b1, 25'h0000000, 25'h0800000, 26'h2000000, 27'h0000000); wait_drain();
        issue(1'b1, 25'h0000000, 25'h1200000, 26'h3000000, 27'h0000000); wait_drain();
        issue(1'b1, 25'h0000000, 25'h0C80000, 26'h2800000, 27'h0000000); wait_drain();
        issue(1'b1, 25'h0000000, 25'h0800001, 26'h2000001, 27'h3FFFFFF); wait_drain();
        issue(1'b0, 25'h1000000, 25'h0000000, 26'h3FFFFFF, 27'h1000000); wait_drain();

        // start pulses during RUN are ignored
        d0 = done_cnt;
        issue(1'b0, 25'h1000000, 25'h1800000, 26'h1555555, 27'h0800000);
        t0 = exp_t_q[0];
        wait_until(t0 + 4);
        mode = 1'b1; divisor_radicand_in = 25'h1200000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_until(t0 + 24);
        mode = 1'b0; dividend_in = 25'h1000000; divisor_radicand_in = 25'h1000000; start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_drain();
        repeat (10) @(negedge clk);
        check("ignored_start_done_count", 64'(done_cnt - d0), 64'd1);
        check("hold_q", 64'(quotient_root), 64'h1555555);
        check("hold_r", 64'(remainder), 64'h0800000);

        // start held high for 100 cycles retriggers every 28 cycles
        d0 = done_cnt;
        @(negedge clk);
        mode = 1'b0; dividend_in = 25'h1000000; divisor_radicand_in = 25'h1800000; start = 1'b1;
        @(negedge clk);
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({26'h1555555, 27'h0800000});
            exp_t_q.push_back(t0 + 28 * k);
        end
        wait_until(t0 + 99);
        start = 1'b0;
        wait_drain();
        check("held_start_done_count", 64'(done_cnt - d0), 64'd4);

        // reset in the middle of a divide
        d0 = done_cnt;
        issue(1'b0, 25'h1000000, 25'h1C00000, 26'h0000000, 27'h0000000);
        t0 = exp_t_q[0];
        wait_until(t0 + 9);
        reset = 1'b0;
        void'(exp_q.pop_back());
        void'(exp_t_q.pop_back());
        #1;
        check("midreset_busy", 64'(busy), 64'd0);
        check("midreset_done", 64'(done), 64'd0);
        check("midreset_q", 64'(quotient_root), 64'd0);
        check("midreset_r", 64'(remainder), 64'd0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("midreset_no_done", 64'(done_cnt - d0), 64'd0);
        issue(1'b0, 25'h1000000, 25'h1800000, 26'h1555555, 27'h0800000); wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
